// File: rtl/i2c_cfg_writer.sv
// i2c_cfg_writer: three-byte I2C write master (START, address+W, two data
// bytes MSB first, STOP) driving open-drain enables for the pad tristates.
// Each bus bit is four quarter-phases; a phase advances only on the divider tick.
module i2c_cfg_writer #(
    parameter int unsigned QTR_DIV = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        locked,
    input  logic        start,
    input  logic [6:0]  dev_addr,
    input  logic [15:0] wdata,
    input  logic        sda_i,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe
);

    localparam int unsigned      DIV_W    = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QTR_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [1:0]        phase_q;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shreg_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              busy_q;
    logic              done_q;
    logic              ack_err_q;
    logic              scl_oe_q;
    logic              sda_oe_q;
    logic              accept;
    logic              tick;
    logic              in_xfer;

    assign accept  = (state_q == S_IDLE) && start && locked;
    assign tick    = (div_q == DIV_LAST);
    assign in_xfer = (state_q == S_START) || (state_q == S_BIT) ||
                     (state_q == S_ACK)   || (state_q == S_STOP);

    // Next divider count: restart on accept so phase 0 is a full quarter-period.
    always_comb begin
        // NOTE: default first so every path assigns div_d and no latch is inferred.
        div_d = div_q + 1'b1;
        if (accept || tick) begin
            div_d = '0;
        end
    end

    // Quarter-phase divider register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Transfer FSM; bus enables are registered and set on entry to each phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shreg_q    <= 24'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Phase wraps 3 -> 0 on its own, so every state change lands on phase 0.
            if (tick && in_xfer) begin
                phase_q <= phase_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        shreg_q    <= {dev_addr, 1'b0, wdata};
                        ack_err_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        phase_q    <= 2'd0;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= 2'd0;
                        scl_oe_q   <= 1'b0;
                        sda_oe_q   <= 1'b0;
                        state_q    <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        case (phase_q)
                            2'd0:    sda_oe_q <= 1'b1;  // SDA falls with SCL high
                            2'd2:    scl_oe_q <= 1'b1;
                            2'd3:    state_q  <= S_BIT; // SCL low, SDA held low
                            default: ;
                        endcase
                    end
                end

                S_BIT: begin
                    if (tick) begin
                        case (phase_q)
                            2'd0:    sda_oe_q <= ~shreg_q[23];
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd3: begin
                                scl_oe_q  <= 1'b1;
                                shreg_q   <= {shreg_q[22:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    state_q <= S_ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACK: begin
                    if (tick) begin
                        case (phase_q)
                            2'd0:    sda_oe_q <= 1'b0;
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd3: begin
                                scl_oe_q <= 1'b1;
                                if (sda_i) begin
                                    ack_err_q <= 1'b1;
                                end
                                if (sda_i || (byte_cnt_q == 2'd2)) begin
                                    sda_oe_q <= 1'b1;
                                    state_q  <= S_STOP;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 2'd1;
                                    state_q    <= S_BIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        case (phase_q)
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd2:    sda_oe_q <= 1'b0;  // SDA rises with SCL high
                            2'd3: begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end
                            default: ;
                        endcase
                    end
                end

                S_DONE:  state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl_oe  = scl_oe_q;
    assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_cfg_writer.sv
// Bench for i2c_cfg_writer: two instances (QTR_DIV=3 and QTR_DIV=1) share a
// bus decoder and ACK-driving slave model; a scoreboard holds the expected
// outcome of each accepted request and a monitor compares it at done.
module tb_i2c_cfg_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        locked = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [15:0] wdata = '0;
    logic        sel = 1'b0;        // 0: QTR_DIV=3 instance, 1: QTR_DIV=1 instance
    logic        slave_pull = 1'b0;
    int          nack_idx = 3;      // byte index the slave refuses (3 = none)
    int          cyc = 0;

    logic start_a, busy_a, done_a, ack_err_a, scl_oe_a, sda_oe_a, sda_i_a;
    logic start_b, busy_b, done_b, ack_err_b, scl_oe_b, sda_oe_b, sda_i_b;
    logic m_busy, m_done, m_ack_err, m_scl_oe, m_sda_oe;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign sda_i_a = ~(sda_oe_a | slave_pull);
    assign sda_i_b = ~(sda_oe_b | slave_pull);

    assign m_busy    = sel ? busy_b    : busy_a;
    assign m_done    = sel ? done_b    : done_a;
    assign m_ack_err = sel ? ack_err_b : ack_err_a;
    assign m_scl_oe  = sel ? scl_oe_b  : scl_oe_a;
    assign m_sda_oe  = sel ? sda_oe_b  : sda_oe_a;

    i2c_cfg_writer #(.QTR_DIV(3)) u_dut_a (
        .clk(clk), .rst(rst), .locked(locked), .start(start_a),
        .dev_addr(dev_addr), .wdata(wdata), .sda_i(sda_i_a),
        .busy(busy_a), .done(done_a), .ack_err(ack_err_a),
        .scl_oe(scl_oe_a), .sda_oe(sda_oe_a)
    );

    i2c_cfg_writer #(.QTR_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .locked(locked), .start(start_b),
        .dev_addr(dev_addr), .wdata(wdata), .sda_i(sda_i_b),
        .busy(busy_b), .done(done_b), .ack_err(ack_err_b),
        .scl_oe(scl_oe_b), .sda_oe(sda_oe_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         acc;   // cycle number of cycle 0 (first cycle after accept edge)
        int         rel;   // done cycle relative to acc
        bit         err;
        int         nb;    // bytes that appear on the bus
        logic [7:0] b0, b1, b2;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor / decoder state
    bit         prev_scl = 1'b1, prev_sda = 1'b1;
    bit         scl_l, sda_l;
    int         rises = 0, starts = 0, stops = 0, bitcnt = 0, busy_cnt = 0;
    logic [7:0] sh = '0;
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference outcome from the transfer rules: 4 START + 36 per byte + 4 STOP phases.
    function automatic exp_t model(input logic [6:0] a, input logic [15:0] d,
                                   input int nk, input int q, input int acc);
        exp_t e;
        e.nb  = (nk < 3) ? nk + 1 : 3;
        e.err = (nk < 3);
        e.rel = (4 + 36 * e.nb + 4) * q;
        e.acc = acc;
        e.b0  = {a, 1'b0};
        e.b1  = d[15:8];
        e.b2  = d[7:0];
        return e;
    endfunction

    task automatic issue(input logic [6:0] a, input logic [15:0] d, input int nk,
                         output int acc, output int rel, output bit err);
        exp_t e;
        @(negedge clk);
        dev_addr = a;
        wdata    = d;
        nack_idx = nk;
        start    = 1'b1;
        e = model(a, d, nk, sel ? 1 : 3, cyc + 1);
        sbq.push_back(e);
        acc = e.acc;
        rel = e.rel;
        err = e.err;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("txn_timeout_pending", sbq.size(), 0);
        sbq.delete();
        @(negedge clk);
    endtask

    initial begin
        int acc, rel, busy_seen, dn;
        bit err;
        exp_t e;
        logic [7:0] eb[3];

        fork
            // ---------------- stimulus ----------------
            begin
                rst    = 1'b1;
                locked = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_busy",    busy_a,    0);
                check("rst_done",    done_a,    0);
                check("rst_ack_err", ack_err_a, 0);
                check("rst_scl_oe",  scl_oe_a,  0);
                check("rst_sda_oe",  sda_oe_a,  0);
                check("rst_busy_b",  busy_b,    0);
                rst = 1'b0;
                repeat (2) @(negedge clk);

                // Codec word, slave ACKs every byte
                issue(7'h1A, 16'h1E00, 3, acc, rel, err);
                wait_done();

                // No slave: address NACK
                issue(7'h1A, 16'h1E00, 0, acc, rel, err);
                wait_done();
                repeat (5) @(negedge clk);
                check("ack_err_held", m_ack_err, err);

                // Slave NACKs the second byte
                issue(7'h2C, 16'hC3A5, 1, acc, rel, err);
                wait_done();

                // Start mid-transfer with a different address is ignored
                issue(7'h1A, 16'hA55A, 3, acc, rel, err);
                repeat (50) @(negedge clk);
                dev_addr = 7'h55;
                wdata    = 16'h0F0F;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_done();

                // Start held while unlocked is ignored
                locked    = 1'b0;
                start     = 1'b1;
                busy_seen = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (m_busy) busy_seen++;
                end
                start  = 1'b0;
                locked = 1'b1;
                check("busy_while_unlocked", busy_seen, 0);

                // Start in the done cycle ignored, accepted the cycle after
                issue(7'h3B, 16'h1234, 3, acc, rel, err);
                while (cyc < acc + rel) @(negedge clk);
                dev_addr = 7'h44;
                wdata    = 16'hBEEF;
                nack_idx = 3;
                start    = 1'b1;
                @(negedge clk);
                sbq.push_back(model(7'h44, 16'hBEEF, 3, 3, cyc + 1));
                @(negedge clk);
                start = 1'b0;
                wait_done();

                // Reset at cycle 100 of a transfer
                issue(7'h1A, 16'h1E00, 3, acc, rel, err);
                while (cyc < acc + 100) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_cycle",  cyc,      acc + 101);
                check("rst_mid_scl_oe", m_scl_oe, 0);
                check("rst_mid_sda_oe", m_sda_oe, 0);
                check("rst_mid_busy",   m_busy,   0);
                rst = 1'b0;
                sbq.delete();
                dn = 0;
                repeat (400) begin
                    @(negedge clk);
                    if (m_done) dn++;
                end
                check("no_done_after_rst", dn, 0);
                issue(7'h1A, 16'h1E00, 3, acc, rel, err);
                wait_done();

                // QTR_DIV = 1 instance
                sel = 1'b1;
                repeat (2) @(negedge clk);
                issue(7'h1A, 16'h1E00, 3, acc, rel, err);
                wait_done();
                issue(7'h1A, 16'h1E00, 0, acc, rel, err);
                wait_done();

                // Randomized transfers, with locked drops and ignored extra starts
                for (int i = 0; i < 12; i++) begin
                    sel = 1'($urandom_range(0, 1));
                    repeat (2) @(negedge clk);
                    issue(7'($urandom), 16'($urandom), int'($urandom_range(0, 5)) > 3 ? 3
                          : int'($urandom_range(0, 3)), acc, rel, err);
                    if ($urandom_range(0, 1) == 1) locked = 1'b0;
                    repeat ($urandom_range(5, 30)) @(negedge clk);
                    dev_addr = 7'($urandom);
                    wdata    = 16'($urandom);
                    start    = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    wait_done();
                    locked = 1'b1;
                end
            end

            // ---------------- monitor / decoder / slave ----------------
            begin
                forever begin
                    @(negedge clk);
                    scl_l = ~m_scl_oe;
                    sda_l = ~(m_sda_oe | slave_pull);
                    if (prev_scl && scl_l && prev_sda && !sda_l) begin
                        starts++;
                        bitcnt = 0;
                    end
                    if (prev_scl && scl_l && !prev_sda && sda_l) stops++;
                    if (!prev_scl && scl_l) begin
                        rises++;
                        if (bitcnt < 8) sh = {sh[6:0], sda_l};
                        bitcnt++;
                        if (bitcnt == 8) got.push_back(sh);
                        if (bitcnt == 9) bitcnt = 0;
                    end
                    if (prev_scl && !scl_l) begin
                        slave_pull = (bitcnt == 8) && ((got.size() - 1) != nack_idx);
                    end

                    if (m_done === 1'b1) begin
                        if (sbq.size() == 0) begin
                            check("unexpected_done", m_done, 0);
                        end else begin
                            e = sbq.pop_front();
                            eb = '{e.b0, e.b1, e.b2};
                            check("done_cycle",   cyc - e.acc, e.rel);
                            check("ack_err",      m_ack_err,   e.err);
                            check("busy_at_done", m_busy,      0);
                            check("busy_cycles",  busy_cnt,    e.rel);
                            check("bytes_seen",   got.size(),  e.nb);
                            for (int k = 0; k < e.nb && k < got.size(); k++)
                                check($sformatf("byte%0d", k), got[k], eb[k]);
                            check("scl_rises",    rises,  9 * e.nb + 1);
                            check("start_conds",  starts, 1);
                            check("stop_conds",   stops,  1);
                        end
                    end else if (m_busy !== 1'b1) begin
                        rises      = 0;
                        starts     = 0;
                        stops      = 0;
                        bitcnt     = 0;
                        busy_cnt   = 0;
                        slave_pull = 1'b0;
                        got.delete();
                    end else begin
                        busy_cnt++;
                    end
                    prev_scl = scl_l;
                    prev_sda = sda_l;
                end
            end
        join_any

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
